// File: rtl/l4_col_monitor.sv
// rtl/l4_col_monitor.sv - column wavefront search monitor with status AND pipeline
//
// Watches one column of expansion cells while a wavefront grows through it.
// A search starts on start, advances one expansion step per cycle, and ends
// when an expanding row meets a target (found) or when the expansion has not
// changed for STALL_LIM consecutive cycles (stalled). abort cancels a search
// quietly. Separately, the per-row status fields are ANDed through a
// two-stage pipeline that runs continuously.
//
// Ports:
//   clk         rising-edge clock
//   reset_l     asynchronous active-low reset
//   start       begin a search (from IDLE or DONE)
//   abort       cancel the search in progress
//   xo_v        per-row expansion outputs of the column cells
//   tgt_v       per-row target flags
//   status_v    per-row status, row r at [r*STATUS_W +: STATUS_W]
//   status_out  AND of all row status fields, two cycles after sampling
//   busy        search in progress
//   done        one-cycle pulse on the first cycle after a search ends
//   found       last search reached a target
//   found_row   lowest-index row that reached a target
//   stalled     last search ended with no growth
//   step_cnt    expansion cycles in the current or last search (saturating)

module l4_col_monitor #(
  parameter int NROWS     = 32,
  parameter int STATUS_W  = 4,
  parameter int STALL_LIM = 4
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NROWS-1:0]          xo_v,
  input  logic [NROWS-1:0]          tgt_v,
  input  logic [NROWS*STATUS_W-1:0] status_v,
  output logic [STATUS_W-1:0]       status_out,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic [$clog2(NROWS)-1:0]  found_row,
  output logic                      stalled,
  output logic [15:0]               step_cnt
);

  localparam int RW      = $clog2(NROWS);
  localparam int NGROUPS = (NROWS + 7) / 8;
  localparam logic [3:0] STALL_LIM_V = 4'(STALL_LIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NROWS-1:0] xo_q, xo_d;
  logic [3:0]       stall_q, stall_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [RW-1:0]    row_q, row_d;
  logic             stalled_q, stalled_d;
  logic [15:0]      step_q, step_d;

  logic [NROWS-1:0] hit;
  logic [RW-1:0]    hit_row;
  logic             no_growth;
  logic [3:0]       stall_inc;

  assign hit       = xo_v & tgt_v;
  assign no_growth = (xo_v == xo_q);
  assign stall_inc = stall_q + 4'd1;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    hit_row = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (hit[r]) hit_row = RW'(r);
    end
  end

  always_comb begin
    state_d   = state_q;
    xo_d      = xo_q;
    stall_d   = stall_q;
    done_d    = 1'b0;
    found_d   = found_q;
    row_d     = row_q;
    stalled_d = stalled_q;
    step_d    = step_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = EXPAND;
          xo_d      = '0;
          stall_d   = '0;
          found_d   = 1'b0;
          row_d     = '0;
          stalled_d = 1'b0;
          step_d    = '0;
        end
      end
      EXPAND: begin
        if (abort) begin
          // Quiet cancel: no done pulse, step count left as it was.
          state_d   = IDLE;
          found_d   = 1'b0;
          stalled_d = 1'b0;
        end else begin
          xo_d    = xo_v;
          step_d  = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
          stall_d = no_growth ? stall_inc : 4'd0;
          if (|hit) begin
            state_d = DONE;
            found_d = 1'b1;
            row_d   = hit_row;
            done_d  = 1'b1;
          end else if (no_growth && (stall_inc == STALL_LIM_V)) begin
            state_d   = DONE;
            stalled_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= IDLE;
      xo_q      <= '0;
      stall_q   <= '0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      row_q     <= '0;
      stalled_q <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      xo_q      <= xo_d;
      stall_q   <= stall_d;
      done_q    <= done_d;
      found_q   <= found_d;
      row_q     <= row_d;
      stalled_q <= stalled_d;
      step_q    <= step_d;
    end
  end

  assign busy      = (state_q == EXPAND);
  assign done      = done_q;
  assign found     = found_q;
  assign found_row = row_q;
  assign stalled   = stalled_q;
  assign step_cnt  = step_q;

  // Status AND tree: groups of up to 8 rows, then across groups. Two
  // register stages regardless of NROWS keeps the latency fixed.
  logic [STATUS_W-1:0] grp_and [NGROUPS];
  logic [STATUS_W-1:0] grp_q   [NGROUPS];
  logic [STATUS_W-1:0] all_and;

  always_comb begin
    for (int g = 0; g < NGROUPS; g++) grp_and[g] = '1;
    for (int r = 0; r < NROWS; r++) begin
      grp_and[r/8] = grp_and[r/8] & status_v[r*STATUS_W +: STATUS_W];
    end
  end

  always_comb begin
    all_and = '1;
    for (int g = 0; g < NGROUPS; g++) all_and = all_and & grp_q[g];
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int g = 0; g < NGROUPS; g++) grp_q[g] <= '1;
      status_out <= '1;
    end else begin
      for (int g = 0; g < NGROUPS; g++) grp_q[g] <= grp_and[g];
      status_out <= all_and;
    end
  end

endmodule

// File: tb/tb_l4_col_monitor.sv
// tb/tb_l4_col_monitor.sv - scoreboard bench for l4_col_monitor

module tb_l4_col_monitor;

  localparam int NROWS = 32;
  localparam int SW    = 4;
  localparam int SL    = 4;

  logic              clk = 1'b0;
  logic              reset_l;
  logic              start;
  logic              abort;
  logic [NROWS-1:0]  xo_v;
  logic [NROWS-1:0]  tgt_v;
  logic [NROWS*SW-1:0] status_v;
  logic [SW-1:0]     status_out;
  logic              busy;
  logic              done;
  logic              found;
  logic [4:0]        found_row;
  logic              stalled;
  logic [15:0]       step_cnt;

  always #5 clk = ~clk;

  l4_col_monitor #(.NROWS(NROWS), .STATUS_W(SW), .STALL_LIM(SL)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .start      (start),
    .abort      (abort),
    .xo_v       (xo_v),
    .tgt_v      (tgt_v),
    .status_v   (status_v),
    .status_out (status_out),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .found_row  (found_row),
    .stalled    (stalled),
    .step_cnt   (step_cnt)
  );

  typedef struct {
    logic        found;
    logic [4:0]  row;
    logic        stalled;
    logic [15:0] steps;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pat_xo[$];
  logic [31:0] pat_tgt[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input string tag, input logic f, input logic [4:0] r,
                        input logic s, input logic [15:0] n);
    exp_t e;
    e.found = f; e.row = r; e.stalled = s; e.steps = n;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_step0"}, 32'(step_cnt), 32'd0);
  endtask

  // Feed the pattern queues one entry per cycle (last entry held) until done.
  task automatic run_pattern(input string tag, input int max_cyc, input int start_at);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      int kx, kt;
      kx = (i < pat_xo.size())  ? i : pat_xo.size() - 1;
      kt = (i < pat_tgt.size()) ? i : pat_tgt.size() - 1;
      xo_v  = pat_xo[kx];
      tgt_v = pat_tgt[kt];
      start = (i == start_at);
      tick();
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_found"},   32'(found),     32'(e.found));
        chk({tag, "_row"},     32'(found_row), 32'(e.row));
        chk({tag, "_stalled"}, 32'(stalled),   32'(e.stalled));
        chk({tag, "_steps"},   32'(step_cnt),  32'(e.steps));
        chk({tag, "_busy_lo"}, 32'(busy),      32'd0);
        xo_v  = 32'hFFFF_FFFF;
        tgt_v = 32'h0;
        tick();
        chk({tag, "_done_1cyc"},   32'(done),     32'd0);
        chk({tag, "_found_hold"},  32'(found),    32'(e.found));
        chk({tag, "_steps_hold"},  32'(step_cnt), 32'(e.steps));
        chk({tag, "_stall_hold"},  32'(stalled),  32'(e.stalled));
      end
    end
  endtask

  function automatic logic [NROWS*SW-1:0] status_with(input int r0, input logic [3:0] v0,
                                                      input int r1, input logic [3:0] v1);
    logic [NROWS*SW-1:0] s;
    s = '1;
    if (r0 >= 0) s[r0*SW +: SW] = v0;
    if (r1 >= 0) s[r1*SW +: SW] = v1;
    return s;
  endfunction

  initial begin
    reset_l  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    xo_v     = '0;
    tgt_v    = '0;
    status_v = '1;
    #12;
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_done",    32'(done),       32'd0);
    chk("rst_found",   32'(found),      32'd0);
    chk("rst_row",     32'(found_row),  32'd0);
    chk("rst_stalled", 32'(stalled),    32'd0);
    chk("rst_steps",   32'(step_cnt),   32'd0);
    chk("rst_status",  32'(status_out), 32'hF);
    @(negedge clk);
    reset_l = 1'b1;
    tick();

    // Hit: expansion 1,3,7,... reaches target bit 12 on the 13th cycle.
    pat_xo.delete(); pat_tgt.delete();
    for (int i = 1; i <= 13; i++) pat_xo.push_back((32'd1 << i) - 32'd1);
    pat_tgt.push_back(32'h0000_1000);
    launch("hit", 1'b1, 5'd12, 1'b0, 16'd13);
    run_pattern("hit", 40, -1);

    // Stall: constant 3; start mid-search must be ignored.
    pat_xo.delete(); pat_tgt.delete();
    pat_xo.push_back(32'h3);
    pat_tgt.push_back(32'h0);
    launch("stall", 1'b0, 5'd0, 1'b1, 16'd5);
    run_pattern("stall", 20, 2);

    // Stall count restarts on growth.
    pat_xo.delete(); pat_tgt.delete();
    pat_xo = '{32'h3, 32'h3, 32'h3, 32'h7};
    pat_tgt.push_back(32'h0);
    launch("stall2", 1'b0, 5'd0, 1'b1, 16'd8);
    run_pattern("stall2", 20, -1);

    // Hit on the same cycle as the 4th equal cycle; lowest hit row is 5.
    pat_xo.delete(); pat_tgt.delete();
    pat_xo.push_back(32'hF0);
    pat_tgt = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA0};
    launch("coinc", 1'b1, 5'd5, 1'b0, 16'd5);
    run_pattern("coinc", 20, -1);

    // Abort at step 6, then restart.
    start = 1'b1; tick(); start = 1'b0;
    tgt_v = '0;
    for (int i = 1; i <= 6; i++) begin
      xo_v = (32'd1 << i) - 32'd1;
      tick();
    end
    chk("abort_pre_steps", 32'(step_cnt), 32'd6);
    abort = 1'b1;
    xo_v  = 32'hFF;
    tick();
    abort = 1'b0;
    chk("abort_busy",    32'(busy),     32'd0);
    chk("abort_done",    32'(done),     32'd0);
    chk("abort_steps",   32'(step_cnt), 32'd6);
    chk("abort_found",   32'(found),    32'd0);
    chk("abort_stalled", 32'(stalled),  32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_ign", 32'(busy),    32'd0);
    chk("abort_idle_done", 32'(done),   32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_busy",  32'(busy),     32'd1);
    chk("restart_steps", 32'(step_cnt), 32'd0);
    xo_v = 32'h1;
    tick();
    chk("restart_step1", 32'(step_cnt), 32'd1);

    // Abort beats a coincident hit.
    abort = 1'b1;
    xo_v  = 32'h3;
    tgt_v = 32'h2;
    tick();
    abort = 1'b0;
    chk("abort_hit_busy",  32'(busy),  32'd0);
    chk("abort_hit_found", 32'(found), 32'd0);
    chk("abort_hit_done",  32'(done),  32'd0);
    tgt_v = '0;

    // Status pipeline: two-cycle latency, single-cycle pulses.
    status_v = status_with(31, 4'b1011, -1, 4'h0);
    tick();
    status_v = '1;
    chk("status_lat1", 32'(status_out), 32'hF);
    tick();
    chk("status_lat2", 32'(status_out), 32'hB);
    tick();
    chk("status_back", 32'(status_out), 32'hF);
    status_v = status_with(3, 4'b0110, 20, 4'b1100);
    tick();
    status_v = '1;
    tick();
    chk("status_multi", 32'(status_out), 32'h4);
    tick();
    chk("status_multi_back", 32'(status_out), 32'hF);

    // Asynchronous reset mid-search, then a normal search.
    start = 1'b1; tick(); start = 1'b0;
    xo_v = 32'h1; tick();
    xo_v = 32'h3; tick();
    status_v = status_with(0, 4'h0, -1, 4'h0);
    tick();
    status_v = '1;
    #2;
    reset_l = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),       32'd0);
    chk("arst_done",   32'(done),       32'd0);
    chk("arst_steps",  32'(step_cnt),   32'd0);
    chk("arst_found",  32'(found),      32'd0);
    chk("arst_status", 32'(status_out), 32'hF);
    #1;
    reset_l = 1'b1;
    pat_xo.delete(); pat_tgt.delete();
    for (int i = 1; i <= 13; i++) pat_xo.push_back((32'd1 << i) - 32'd1);
    pat_tgt.push_back(32'h0000_1000);
    launch("post_rst", 1'b1, 5'd12, 1'b0, 16'd13);
    run_pattern("post_rst", 40, -1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l4_col_monitor.md
L4_COL_MONITOR -- requirements
Module: l4_col_monitor

Interface
REQ-001 SHALL have parameter NROWS, default 32, rows per column (legal range 2..64).
REQ-002 SHALL have parameter STATUS_W, default 4, per-row status width.
REQ-003 SHALL have parameter STALL_LIM, default 4, consecutive no-growth cycles that end a search (legal range 1..15).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_l, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: begin a wavefront search.
REQ-007 SHALL have port abort, input, 1: cancel the search in progress.
REQ-008 SHALL have port xo_v, input, NROWS: per-row expansion outputs of the column cells.
REQ-009 SHALL have port tgt_v, input, NROWS: per-row target flags.
REQ-010 SHALL have port status_v, input, NROWS*STATUS_W: row r status in bits [r*STATUS_W +: STATUS_W].
REQ-011 SHALL have port status_out, output, STATUS_W: AND of all row status fields, registered.
REQ-012 SHALL have port busy, output, 1: search in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a search ends.
REQ-014 SHALL have port found, output, 1: target reached.
REQ-015 SHALL have port found_row, output, clog2(NROWS): lowest-index row that reached a target.
REQ-016 SHALL have port stalled, output, 1: search ended with no growth.
REQ-017 SHALL have port step_cnt, output, 16: expansion cycles in the current or last search.

Function
REQ-018 SHALL implement FSM states IDLE, EXPAND and DONE; busy SHALL be 1 only in EXPAND.
REQ-019 SHALL transition IDLE->EXPAND on start, and DONE->EXPAND on start.
- On that transition: clear found, found_row, stalled, step_cnt and the stall counter.
- Load xo_q with all zeros.
REQ-020 In EXPAND, SHALL per cycle:
- register xo_q <= xo_v;
- increment step_cnt, saturating at 16'hFFFF.
REQ-021 In EXPAND, SHALL compute hit = xo_v & tgt_v.
- If hit is nonzero: go to DONE, set found=1, and set found_row to the index of the lowest set bit of hit.
REQ-022 In EXPAND, SHALL compare xo_v with xo_q.
- If equal: increment the stall counter.
- Otherwise: clear the stall counter.
- If the incremented count equals STALL_LIM and there is no hit: go to DONE with stalled=1.
REQ-023 SHALL give a hit priority over a stall when both occur in the same cycle: found=1, stalled=0.
REQ-024 SHALL assert done for exactly the single cycle after entry into DONE from EXPAND.
REQ-025 SHALL hold found, found_row, stalled and step_cnt stable in DONE and IDLE until the next start.
REQ-026 SHALL treat abort in EXPAND as follows:
- go to IDLE with no done pulse and found=stalled=0;
- step_cnt retains its value.
REQ-027 SHALL give abort priority over hit and stall when they coincide.
REQ-028 SHALL ignore start while in EXPAND.
REQ-029 SHALL ignore abort outside EXPAND.
REQ-030 SHALL compute status_out as a two-stage pipeline, latency exactly 2 cycles for every legal NROWS.
- Stage 1 ANDs status fields in groups of up to 8 rows.
- Stage 2 ANDs the group results.
- The pipeline runs in every FSM state.
REQ-031 SHALL compute xo_v, tgt_v and status_v only synchronously; there is no combinational input-to-output path.

Reset
REQ-032 On reset_l=0, SHALL asynchronously set:
- FSM to IDLE;
- busy=0, done=0, found=0, found_row=0, stalled=0, step_cnt=0;
- xo_q=0, stall counter=0, both status pipeline stages all ones (so status_out=all ones).
REQ-033 SHALL abandon a search when reset is asserted in EXPAND, with no done pulse.
REQ-034 SHALL release reset synchronously; the first start is accepted on the first rising edge with reset_l=1.

Verification
REQ-035 Hit test (NROWS=32, tgt_v=32'h0000_1000).
- Stimulus: start; xo_v grows 1, 3, 7, ..., one bit per cycle, until bit 12 is set.
- Response: done pulse, found=1, found_row=12, step_cnt=13, stalled=0.
REQ-036 Stall test (STALL_LIM=4, tgt_v=0).
- Stimulus: start; xo_v=32'h3 held constant.
- Response: stalled=1 and done after 5 EXPAND cycles (1 growth + 4 equal), found=0.
REQ-037 Hit-versus-stall coincidence test.
- Stimulus: hit and the 4th equal cycle occur together.
- Response: found=1, stalled=0, found_row set to the lowest hit row.
REQ-038 Abort and restart test.
- Stimulus: abort at step 6, then start.
- Response: busy falls with no done pulse and step_cnt=6; after start, step_cnt restarts from 0.
REQ-039 Status pipeline test.
- Stimulus: status_v all ones except row 31 field = 4'b1011, applied for one cycle.
- Response: status_out=4'b1011 exactly 2 cycles later, then all ones.
REQ-040 Reset test.
- Stimulus: reset_l pulsed low mid-EXPAND, asynchronously.
- Response: all outputs go to reset values immediately; no done pulse; next start is accepted normally.
